// File: rtl/rv32i_trap_ctrl.sv
// rv32i_trap_ctrl: trap sequencer feeding the CSR file trap interface.
// Arbitrates mem/ex exceptions, MRET and synchronized machine interrupts,
// drains the pipeline, pulses the CSR trigger and then redirects fetch.
// Optional macro TRAP_VECTORED_EN: vectored interrupt dispatch when
// mtvec_in[1:0] == 2'b01 (exceptions always use the mtvec base).
module rv32i_trap_ctrl #(
   parameter int DRAIN_CYCLES    = 2,
   parameter int IRQ_SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_instr,
   input  logic        ex_illegal,
   input  logic        ex_ecall,
   input  logic        ex_ebreak,
   input  logic        ex_mret,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_load_misaligned,
   input  logic        mem_store_misaligned,
   input  logic [31:0] mem_addr,
   input  logic        irq_timer,
   input  logic        irq_external,
   input  logic        mstatus_mie,
   input  logic [31:0] mie_in,
   input  logic [31:0] mtvec_in,
   input  logic [31:0] mepc_in,
   output logic        exception_trigger,
   output logic [31:0] exception_cause,
   output logic [31:0] exception_pc,
   output logic [31:0] exception_value,
   output logic        mret_trigger,
   output logic        pipe_flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIRECT} state_t;

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   state_t                     state_q;
   logic [3:0]                 cnt_q;
   logic                       is_mret_q;
   logic                       is_irq_q;
   logic                       exc_trig_q;
   logic                       mret_trig_q;
   logic                       flush_q;
   logic                       redir_vld_q;
   logic [31:0]                cause_q;
   logic [31:0]                pc_q;
   logic [31:0]                value_q;
   logic [31:0]                redir_pc_q;
   logic [IRQ_SYNC_STAGES-1:0] tmr_sync_q;
   logic [IRQ_SYNC_STAGES-1:0] ext_sync_q;

   logic                       tmr_sync;
   logic                       ext_sync;
   logic                       ext_pend;
   logic                       tmr_pend;
   logic                       req_d;
   logic                       req_mret_d;
   logic                       req_irq_d;
   logic [31:0]                cause_d;
   logic [31:0]                pc_d;
   logic [31:0]                value_d;
   logic [31:0]                trap_target;
   logic                       unused_ok;

   // Shift the asynchronous interrupt levels into the clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_sync_q <= '0;
         ext_sync_q <= '0;
      end else begin
         tmr_sync_q <= {tmr_sync_q[IRQ_SYNC_STAGES-2:0], irq_timer};
         ext_sync_q <= {ext_sync_q[IRQ_SYNC_STAGES-2:0], irq_external};
      end
   end

   assign tmr_sync = tmr_sync_q[IRQ_SYNC_STAGES-1];
   assign ext_sync = ext_sync_q[IRQ_SYNC_STAGES-1];
   assign ext_pend = mstatus_mie & ext_sync & mie_in[11];
   assign tmr_pend = mstatus_mie & tmr_sync & mie_in[7];

   // Fixed-priority arbitration of the requests seen while idle.
   always_comb begin
      req_d      = 1'b0;
      req_mret_d = 1'b0;
      req_irq_d  = 1'b0;
      cause_d    = 32'd0;
      pc_d       = 32'd0;
      value_d    = 32'd0;
      if (mem_valid && mem_store_misaligned) begin
         req_d   = 1'b1;
         cause_d = 32'd6;
         pc_d    = mem_pc;
         value_d = mem_addr;
      end else if (mem_valid && mem_load_misaligned) begin
         req_d   = 1'b1;
         cause_d = 32'd4;
         pc_d    = mem_pc;
         value_d = mem_addr;
      end else if (ex_valid && ex_illegal) begin
         req_d   = 1'b1;
         cause_d = 32'd2;
         pc_d    = ex_pc;
         value_d = ex_instr;
      end else if (ex_valid && ex_ebreak) begin
         req_d   = 1'b1;
         cause_d = 32'd3;
         pc_d    = ex_pc;
         value_d = ex_pc;
      end else if (ex_valid && ex_ecall) begin
         req_d   = 1'b1;
         cause_d = 32'd11;
         pc_d    = ex_pc;
      end else if (ex_valid && ex_mret) begin
         req_d      = 1'b1;
         req_mret_d = 1'b1;
      end else if (ex_valid && (ext_pend || tmr_pend)) begin
         req_d     = 1'b1;
         req_irq_d = 1'b1;
         cause_d   = ext_pend ? 32'h8000_000B : 32'h8000_0007;
         pc_d      = ex_pc;
      end
   end

   // Trap handler address: mtvec base, optionally offset by cause for interrupts.
   always_comb begin
      trap_target = {mtvec_in[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
      if (is_irq_q && (mtvec_in[1:0] == 2'b01))
         trap_target = {mtvec_in[31:2], 2'b00} + {25'd0, cause_q[4:0], 2'b00};
`else
      trap_target = {mtvec_in[31:2], 2'b00};
`endif
   end

   // Sequencer: IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE, all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         is_mret_q   <= 1'b0;
         is_irq_q    <= 1'b0;
         exc_trig_q  <= 1'b0;
         mret_trig_q <= 1'b0;
         flush_q     <= 1'b0;
         redir_vld_q <= 1'b0;
         cause_q     <= 32'd0;
         pc_q        <= 32'd0;
         value_q     <= 32'd0;
         redir_pc_q  <= 32'd0;
      end else begin
         exc_trig_q  <= 1'b0;
         mret_trig_q <= 1'b0;
         redir_vld_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_d) begin
                  state_q   <= S_DRAIN;
                  cnt_q     <= DRAIN_INIT;
                  flush_q   <= 1'b1;
                  is_mret_q <= req_mret_d;
                  is_irq_q  <= req_irq_d;
                  // MRET leaves the last trap record untouched.
                  if (!req_mret_d) begin
                     cause_q <= cause_d;
                     pc_q    <= pc_d;
                     value_q <= value_d;
                  end
               end
            end
            S_DRAIN: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= S_COMMIT;
                  exc_trig_q  <= !is_mret_q;
                  mret_trig_q <= is_mret_q;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_COMMIT: begin
               // Target is captured so it is presented together with redirect_valid.
               state_q     <= S_REDIRECT;
               redir_vld_q <= 1'b1;
               redir_pc_q  <= is_mret_q ? {mepc_in[31:2], 2'b00} : trap_target;
            end
            S_REDIRECT: begin
               state_q <= S_IDLE;
               flush_q <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   assign exception_trigger = exc_trig_q;
   assign exception_cause   = cause_q;
   assign exception_pc      = pc_q;
   assign exception_value   = value_q;
   assign mret_trigger      = mret_trig_q;
   assign pipe_flush        = flush_q;
   assign redirect_valid    = redir_vld_q;
   assign redirect_pc       = redir_pc_q;

   assign unused_ok = ^{mie_in[31:12], mie_in[10:8], mie_in[6:0],
                        mtvec_in[1:0], mepc_in[1:0], is_irq_q};

endmodule

// File: tb/tb_rv32i_trap_ctrl.sv
// Scoreboard bench for rv32i_trap_ctrl (DRAIN_CYCLES=2, IRQ_SYNC_STAGES=2).
module tb_rv32i_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 0, ex_illegal = 0, ex_ecall = 0, ex_ebreak = 0, ex_mret = 0;
   logic [31:0] ex_pc = 0, ex_instr = 0;
   logic        mem_valid = 0, mem_load_misaligned = 0, mem_store_misaligned = 0;
   logic [31:0] mem_pc = 0, mem_addr = 0;
   logic        irq_timer = 0, irq_external = 0, mstatus_mie = 0;
   logic [31:0] mie_in = 0, mtvec_in = 32'h200, mepc_in = 0;
   logic        exception_trigger, mret_trigger, pipe_flush, redirect_valid;
   logic [31:0] exception_cause, exception_pc, exception_value, redirect_pc;

   typedef struct {
      bit          is_mret;
      logic [31:0] cause;
      logic [31:0] pc;
      logic [31:0] value;
      logic [31:0] rpc;
      int          trig_cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   have_cur = 0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   rv32i_trap_ctrl #(.DRAIN_CYCLES(2), .IRQ_SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
      .ex_illegal(ex_illegal), .ex_ecall(ex_ecall), .ex_ebreak(ex_ebreak), .ex_mret(ex_mret),
      .mem_valid(mem_valid), .mem_pc(mem_pc),
      .mem_load_misaligned(mem_load_misaligned), .mem_store_misaligned(mem_store_misaligned),
      .mem_addr(mem_addr), .irq_timer(irq_timer), .irq_external(irq_external),
      .mstatus_mie(mstatus_mie), .mie_in(mie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
      .exception_trigger(exception_trigger), .exception_cause(exception_cause),
      .exception_pc(exception_pc), .exception_value(exception_value),
      .mret_trigger(mret_trigger), .pipe_flush(pipe_flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic expect_trap(input bit m, input logic [31:0] c, input logic [31:0] p,
                              input logic [31:0] v, input logic [31:0] r, input int lat);
      exp_t e;
      e.is_mret = m; e.cause = c; e.pc = p; e.value = v; e.rpc = r;
      e.trig_cyc = cyc + lat;
      exp_q.push_back(e);
   endtask

   task automatic clear_reqs();
      ex_valid = 0; ex_illegal = 0; ex_ecall = 0; ex_ebreak = 0; ex_mret = 0;
      mem_valid = 0; mem_load_misaligned = 0; mem_store_misaligned = 0;
      irq_timer = 0; irq_external = 0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a trigger or redirect.
   always @(negedge clk) begin
      if (!rst) begin
         if (exception_trigger || mret_trigger) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_trigger", {30'd0, mret_trigger, exception_trigger}, 32'd0);
            end else begin
               cur = exp_q.pop_front();
               have_cur = 1;
               chk("exception_trigger", {31'd0, exception_trigger}, {31'd0, !cur.is_mret});
               chk("mret_trigger", {31'd0, mret_trigger}, {31'd0, cur.is_mret});
               chk("trigger_cycle", cyc, cur.trig_cyc);
               chk("flush_at_commit", {31'd0, pipe_flush}, 32'd1);
               if (!cur.is_mret) begin
                  chk("cause", exception_cause, cur.cause);
                  chk("epc", exception_pc, cur.pc);
                  chk("tval", exception_value, cur.value);
               end
            end
         end
         if (redirect_valid) begin
            if (!have_cur) begin
               chk("unexpected_redirect", {31'd0, redirect_valid}, 32'd0);
            end else begin
               have_cur = 0;
               chk("redirect_pc", redirect_pc, cur.rpc);
               chk("redirect_cycle", cyc, cur.trig_cyc + 1);
               chk("flush_at_redirect", {31'd0, pipe_flush}, 32'd1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      wait_cycles(3);
      chk("rst_exc_trig", {31'd0, exception_trigger}, 32'd0);
      chk("rst_mret_trig", {31'd0, mret_trigger}, 32'd0);
      chk("rst_flush", {31'd0, pipe_flush}, 32'd0);
      chk("rst_redir_vld", {31'd0, redirect_valid}, 32'd0);
      chk("rst_cause", exception_cause, 32'd0);
      chk("rst_redir_pc", redirect_pc, 32'd0);
      rst = 0;
      wait_cycles(2);

      // Illegal instruction
      ex_valid = 1; ex_illegal = 1; ex_pc = 32'h100; ex_instr = 32'hFFFF_FFFF; mtvec_in = 32'h200;
      expect_trap(0, 32'd2, 32'h100, 32'hFFFF_FFFF, 32'h200, 3);
      wait_cycles(1); clear_reqs();
      chk("flush_in_drain", {31'd0, pipe_flush}, 32'd1);
      wait_cycles(6);

      // Store misaligned beats ecall
      mem_valid = 1; mem_store_misaligned = 1; mem_pc = 32'h80; mem_addr = 32'h1003;
      ex_valid = 1; ex_ecall = 1; ex_pc = 32'h500;
      expect_trap(0, 32'd6, 32'h80, 32'h1003, 32'h200, 3);
      wait_cycles(1); clear_reqs(); wait_cycles(6);

      // MRET
      ex_valid = 1; ex_mret = 1; ex_pc = 32'h600; mepc_in = 32'h347;
      expect_trap(1, 32'd0, 32'd0, 32'd0, 32'h344, 3);
      wait_cycles(1); clear_reqs(); wait_cycles(6);

      // Load misaligned beats MRET
      mem_valid = 1; mem_load_misaligned = 1; mem_pc = 32'h84; mem_addr = 32'h2001;
      ex_valid = 1; ex_mret = 1;
      expect_trap(0, 32'd4, 32'h84, 32'h2001, 32'h200, 3);
      wait_cycles(1); clear_reqs(); wait_cycles(6);

      // EBREAK beats ECALL; exception ignores vectored mode
      mtvec_in = 32'h201;
      ex_valid = 1; ex_ebreak = 1; ex_ecall = 1; ex_pc = 32'h300;
      expect_trap(0, 32'd3, 32'h300, 32'h300, 32'h200, 3);
      wait_cycles(1); clear_reqs(); wait_cycles(6);
      mtvec_in = 32'h200;

      // ECALL; unqualified mem fault ignored
      mem_valid = 0; mem_store_misaligned = 1; mem_pc = 32'h90; mem_addr = 32'h7;
      ex_valid = 1; ex_ecall = 1; ex_pc = 32'h400;
      expect_trap(0, 32'd11, 32'h400, 32'd0, 32'h200, 3);
      wait_cycles(1); clear_reqs(); wait_cycles(6);

      // Timer interrupt after two-stage sync
      mie_in = 32'h80; mstatus_mie = 1; irq_timer = 1; ex_valid = 1; ex_pc = 32'h40;
      expect_trap(0, 32'h8000_0007, 32'h40, 32'd0, 32'h200, 5);
      wait_cycles(3); clear_reqs(); wait_cycles(7);

      // Interrupt masked by mstatus.MIE
      mstatus_mie = 0; irq_timer = 1; ex_valid = 1; ex_pc = 32'h44;
      wait_cycles(8);
      chk("masked_irq_flush", {31'd0, pipe_flush}, 32'd0);
      clear_reqs(); wait_cycles(4);

      // External beats timer; vectored target when enabled
      mstatus_mie = 1; mie_in = 32'h880; mtvec_in = 32'h201;
      irq_timer = 1; irq_external = 1; ex_valid = 1; ex_pc = 32'h48;
`ifdef TRAP_VECTORED_EN
      expect_trap(0, 32'h8000_000B, 32'h48, 32'd0, 32'h22C, 5);
`else
      expect_trap(0, 32'h8000_000B, 32'h48, 32'd0, 32'h200, 5);
`endif
      wait_cycles(3); clear_reqs(); wait_cycles(7);
      mstatus_mie = 0; mie_in = 0; mtvec_in = 32'h200;

      // Reset during DRAIN aborts the sequence
      ex_valid = 1; ex_illegal = 1; ex_pc = 32'h700; ex_instr = 32'h1234;
      wait_cycles(1); clear_reqs();
      chk("pre_rst_flush", {31'd0, pipe_flush}, 32'd1);
      #2 rst = 1;
      #1;
      chk("midrst_exc_trig", {31'd0, exception_trigger}, 32'd0);
      chk("midrst_flush", {31'd0, pipe_flush}, 32'd0);
      chk("midrst_redir_vld", {31'd0, redirect_valid}, 32'd0);
      chk("midrst_cause", exception_cause, 32'd0);
      chk("midrst_epc", exception_pc, 32'd0);
      chk("midrst_tval", exception_value, 32'd0);
      chk("midrst_redir_pc", redirect_pc, 32'd0);
      wait_cycles(1); rst = 0;
      wait_cycles(8);
      chk("post_rst_flush", {31'd0, pipe_flush}, 32'd0);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      chk("no_pending_redirect", {31'd0, have_cur}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
